// File: rtl/instr_sequencer.sv
// instr_sequencer: five-state decode/read/execute/writeback sequencer with retired-instruction counter
module instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [15:0]      instr_data,
    output logic             instr_ready,
    output logic [2:0]       rf_rs_addr,
    output logic [2:0]       rf_rt_addr,
    output logic             rf_re,
    output logic [2:0]       alu_op,
    output logic             alu_en,
    output logic [2:0]       rf_wr_addr,
    output logic             rf_we,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB} state_t;
    state_t state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [2:0] rs_q, rs_d, rt_q, rt_d, op_q, op_d, wr_q, wr_d;
    logic nop_q, nop_d, illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0] opc;
    logic is_alu, is_nop;
    assign opc    = instr_q[15:10];
    assign is_alu = (opc <= 6'd4) && !instr_q[0];
    assign is_nop = (opc == 6'h3f) && !instr_q[0];
    // Next-state logic; addresses and op only change on entry to the state that strobes them
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        op_d      = op_q;
        wr_d      = wr_q;
        nop_d     = nop_q;
        illegal_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: if (instr_valid) begin
                instr_d = instr_data;
                state_d = DECODE;
            end
            DECODE: begin
                nop_d     = is_nop;
                illegal_d = !is_alu && !is_nop;
                state_d   = is_alu ? READ : is_nop ? WB : IDLE;
                rs_d      = is_alu ? instr_q[9:7] : rs_q;
                rt_d      = is_alu ? instr_q[6:4] : rt_q;
            end
            READ: begin
                op_d    = opc[2:0];
                state_d = EXEC;
            end
            EXEC: begin
                wr_d    = instr_q[3:1];
                state_d = WB;
            end
            WB: begin
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State register; asynchronous reset aborts any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            op_q      <= '0;
            wr_q      <= '0;
            nop_q     <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
            nop_q     <= nop_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end
    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rf_re       = (state_q == READ);
    assign alu_en      = (state_q == EXEC);
    assign rf_we       = (state_q == WB) && !nop_q;
    assign illegal     = illegal_q;
    assign rf_rs_addr  = rs_q;
    assign rf_rt_addr  = rt_q;
    assign alu_op      = op_q;
    assign rf_wr_addr  = wr_q;
    assign retired_cnt = cnt_q;
endmodule
